vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameter X0, default 64: left pixel column of the 512-wide Hack screen window.
REQ-002 SHALL have parameter Y0, default 112: top line of the 256-high Hack screen window.
REQ-003 SHALL have parameter RD_LAT, default 1: clocks from addressVGA change to valid QVGA.
REQ-004 SHALL have port clk1, input, 1 bit: single clock (25 MHz pixel clock), rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: scan enable.
REQ-007 SHALL have port QVGA, input, 16 bits: screen word returned by the screen memory's video port.
REQ-008 SHALL have port addressVGA, output, 13 bits: screen word address, registered.
REQ-009 SHALL have port pix, output, 1 bit: current pixel, 1 = black, registered.
REQ-010 SHALL have port hsync, output, 1 bit: horizontal sync, active-low, registered.
REQ-011 SHALL have port vsync, output, 1 bit: vertical sync, active-low, registered.
REQ-012 SHALL have port de, output, 1 bit: display-active (640x480 area), registered.
REQ-013 SHALL have port frame_start, output, 1 bit: one-cycle pulse at hc=0, vc=0.

Function
REQ-014 SHALL count hc 0..799 and wrap to 0; vc SHALL increment on hc wrap, counting 0..524 and wrapping to 0.
REQ-015 hc timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 vc timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 de, hsync, vsync, pix and frame_start SHALL share one fixed delay of 1 clock after the counter state they describe.
REQ-018 Window: hc in [X0, X0+511] and vc in [Y0, Y0+255]; outside the window pix=0.
REQ-019 Window pixel (x=hc-X0, y=vc-Y0) SHALL display bit x[3:0] of word y*32 + x[8:4], with bit 0 leftmost (Hack order).
REQ-020 SHALL prefetch by issuing each word address RD_LAT+1 clocks before its first pixel, and SHALL load the 16-bit shift register exactly at the word boundary; pix SHALL show no gap or repeat between words.
REQ-021 addressVGA SHALL stay at the last issued address between fetches and SHALL be 0 during blanking; it SHALL wrap from 8191 to 0 only at frame end.
REQ-022 en=0 SHALL hold hc=vc=0 and force idle outputs (hsync=vsync=1, de=pix=frame_start=0, addressVGA=0); en rising SHALL start at hc=0, vc=0, and frame_start SHALL pulse in that frame's first output cycle.
REQ-023 QVGA SHALL be sampled only on the scheduled load cycle; QVGA changes caused by CPU writes at other times SHALL have no effect until the next fetch.

Reset
REQ-024 rst=1 at a clock edge SHALL set hc=vc=0, clear the shift register, and set the outputs to hsync=1, vsync=1, de=0, pix=0, frame_start=0, addressVGA=0.
REQ-025 rst SHALL take priority over en; deasserting rst mid-frame SHALL start a fresh frame from hc=0, vc=0, with no partial-line output.

Structure
REQ-026 All timing constants (H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33) and the 512x256 window size SHALL live in shared package hack_vga_pkg.
REQ-027 The counters, syncs and de SHALL be a sub-module vga_timing; fetch and shifting SHALL stay in vga_scan_ctrl.

Verification
REQ-028 Run one frame after reset: hsync low exactly 96 clocks per line, vsync low exactly 2 lines, de high 640x480 clocks, frame_start once every 420000 clocks.
REQ-029 Memory model with RD_LAT=1, word 0 = 0x0001, all other words 0: exactly one pix=1, at output column 64, line 112.
REQ-030 Word 8191 = 0x8000, all other words 0: single pix=1 at column 575, line 367; word 31 = 0xFFFF: pix=1 on columns 560..575 of line 112 only.
REQ-031 Checkerboard (even words 0xAAAA, odd words 0x5555): pix alternates 0,1 across each word boundary with no glitch at the 16-pixel seams; addressVGA sequence 0..8191 once per frame.
REQ-032 Assert rst at hc=300, vc=200 for 1 clock: next cycle outputs are idle; counters restart at 0; first frame_start follows 1 clock after release.
REQ-033 Drop en mid-line, then raise it after 10 clocks: outputs stay idle while en=0; on re-enable, frame_start pulses and timing matches REQ-028.

Source files
------------

// File: rtl/hack_vga_pkg.sv
// Shared constants and types for the Hack-computer VGA scan-out path.
// 640x480@60 Hz timing on a 25 MHz pixel clock (800 x 525 clocks per frame)
// and the 512x256 monochrome Hack screen window placed inside it.
package hack_vga_pkg;

   typedef logic [9:0]  cnt_t;   // hc / vc counter value (max 799)
   typedef logic [12:0] addr_t;  // screen word address (8K words)
   typedef logic [15:0] word_t;  // one screen word = 16 pixels

   // Horizontal timing, in pixel clocks
   localparam cnt_t H_ACTIVE = 10'd640;
   localparam cnt_t H_FP     = 10'd16;
   localparam cnt_t H_SYNC   = 10'd96;
   localparam cnt_t H_BP     = 10'd48;
   localparam cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
   localparam cnt_t H_SYNC_S = H_ACTIVE + H_FP;                  // 656
   localparam cnt_t H_SYNC_E = H_SYNC_S + H_SYNC;                // 752, exclusive

   // Vertical timing, in lines
   localparam cnt_t V_ACTIVE = 10'd480;
   localparam cnt_t V_FP     = 10'd10;
   localparam cnt_t V_SYNC   = 10'd2;
   localparam cnt_t V_BP     = 10'd33;
   localparam cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
   localparam cnt_t V_SYNC_S = V_ACTIVE + V_FP;                  // 490
   localparam cnt_t V_SYNC_E = V_SYNC_S + V_SYNC;                // 492, exclusive

   // Hack screen window size
   localparam int WIN_W = 512;
   localparam int WIN_H = 256;

   // lo <= v < hi
   function automatic logic in_span(cnt_t v, cnt_t lo, cnt_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Video read port between the scan controller and the screen memory.
//   addressVGA : word address driven by the scan controller
//   QVGA       : word returned by the memory a fixed latency later
// master = scan controller side, slave = memory side.
interface vga_scan_ctrl_if;
   import hack_vga_pkg::*;

   addr_t addressVGA;
   word_t QVGA;

   modport master (output addressVGA, input QVGA);
   modport slave  (input addressVGA, output QVGA);

endinterface

// File: rtl/vga_timing.sv
// 640x480 raster counters with registered sync / display-enable outputs.
//   clk1, rst      : pixel clock, synchronous active-high reset
//   en             : scan enable; low holds the counters at 0 and idles outputs
//   hc, vc         : live counter state (for the fetch logic in the top)
//   de/hsync/vsync : describe the counter state of the previous clock
//   frame_start    : one-cycle pulse for counter state hc=0, vc=0
module vga_timing
   import hack_vga_pkg::*;
(
   input  logic clk1,
   input  logic rst,
   input  logic en,
   output cnt_t hc,
   output cnt_t vc,
   output logic de,
   output logic hsync,
   output logic vsync,
   output logic frame_start
);

   cnt_t hc_q, hc_d, vc_q, vc_d;
   logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

   always_comb begin
      hc_d    = '0;
      vc_d    = '0;
      de_d    = 1'b0;
      hsync_d = 1'b1;
      vsync_d = 1'b1;
      fs_d    = 1'b0;
      if (en) begin
         de_d    = (hc_q < H_ACTIVE) && (vc_q < V_ACTIVE);
         hsync_d = !in_span(hc_q, H_SYNC_S, H_SYNC_E);
         vsync_d = !in_span(vc_q, V_SYNC_S, V_SYNC_E);
         fs_d    = (hc_q == '0) && (vc_q == '0);
         if (hc_q == H_TOTAL - 10'd1) begin
            hc_d = '0;
            vc_d = (vc_q == V_TOTAL - 10'd1) ? '0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
            vc_d = vc_q;
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         hc_q    <= '0;
         vc_q    <= '0;
         de_q    <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         de_q    <= de_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         fs_q    <= fs_d;
      end
   end

   assign hc          = hc_q;
   assign vc          = vc_q;
   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = fs_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// Hack screen scan-out: fetches 16-bit screen words and shifts them out as
// pixels inside a 512x256 window of a 640x480 raster.
//   clk1, rst, en  : pixel clock, sync active-high reset, scan enable
//   QVGA           : word from the screen memory video port (RD_LAT clocks
//                    after addressVGA changes)
//   addressVGA     : registered word address (0 during blanking)
//   pix            : registered pixel, 1 = black, bit 0 of a word is leftmost
//   hsync, vsync   : active-low syncs; de = display active; frame_start pulse
// All pixel-side outputs lag the counter state they describe by one clock.
module vga_scan_ctrl
   import hack_vga_pkg::*;
#(
   parameter int X0     = 64,
   parameter int Y0     = 112,
   parameter int RD_LAT = 1
) (
   input  logic        clk1,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] QVGA,
   output logic [12:0] addressVGA,
   output logic        pix,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start
);

   localparam cnt_t XS = cnt_t'(X0);
   localparam cnt_t XE = cnt_t'(X0 + WIN_W);
   localparam cnt_t YS = cnt_t'(Y0);
   localparam cnt_t YE = cnt_t'(Y0 + WIN_H);
   // The address register adds one clock on top of the memory latency, so a
   // fetch decided at hc lands in QVGA exactly when the counter reaches hc+LA.
   localparam cnt_t LA = cnt_t'(RD_LAT + 1);

   cnt_t       hc, vc, hf;
   logic [8:0] xf;
   logic [3:0] xl;
   logic [7:0] yr;
   logic       active, v_in, h_in, fetch, load;

   addr_t addr_q, addr_d;
   word_t sr_q, sr_d;
   logic  pix_q, pix_d;

   vga_timing u_timing (
      .clk1        (clk1),
      .rst         (rst),
      .en          (en),
      .hc          (hc),
      .vc          (vc),
      .de          (de),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start)
   );

   always_comb begin
      hf     = hc + LA;             // column whose word must be requested now
      xf     = 9'(hf - XS);
      xl     = 4'(hc - XS);
      yr     = 8'(vc - YS);
      active = (hc < H_ACTIVE) && (vc < V_ACTIVE);
      v_in   = in_span(vc, YS, YE);
      h_in   = in_span(hc, XS, XE);
      fetch  = v_in && in_span(hf, XS, XE) && (xf[3:0] == 4'd0);
      load   = v_in && h_in && (xl == 4'd0);

      addr_d = addr_q;
      sr_d   = sr_q;
      pix_d  = 1'b0;
      if (!en) begin
         addr_d = '0;
         sr_d   = '0;
      end else begin
         // Address holds between fetches; blanking parks it at 0.
         if (!active)
            addr_d = '0;
         else if (fetch)
            addr_d = {yr, xf[8:4]};

         // QVGA is only looked at on the word-boundary cycle; the first pixel
         // goes straight out and the other 15 are kept for shifting.
         if (load) begin
            sr_d  = {1'b0, QVGA[15:1]};
            pix_d = QVGA[0];
         end else if (v_in && h_in) begin
            sr_d  = {1'b0, sr_q[15:1]};
            pix_d = sr_q[0];
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         addr_q <= '0;
         sr_q   <= '0;
         pix_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         sr_q   <= sr_d;
         pix_q  <= pix_d;
      end
   end

   assign addressVGA = addr_q;
   assign pix        = pix_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl. The window is moved to Y0=2 so that
// several window rows are reached within a short run; pixel positions are
// measured from the frame_start output cycle.
module tb_vga_scan_ctrl;
   localparam int X0     = 64;
   localparam int Y0     = 2;
   localparam int RD_LAT = 1;
   localparam int NL     = 12;            // lines watched per pattern
   localparam int IDLE   = 32'h30000;     // {hs,vs,de,pix,fs,addr[12:0]} idle

   logic clk1 = 1'b0;
   logic rst, en;
   logic pix, hsync, vsync, de, frame_start;
   logic [15:0] mem [8192];

   vga_scan_ctrl_if mif();

   always #20 clk1 = ~clk1;

   // Screen memory video port, one clock of read latency.
   always @(posedge clk1) mif.QVGA <= mem[mif.addressVGA];

   vga_scan_ctrl #(.X0(X0), .Y0(Y0), .RD_LAT(RD_LAT)) dut (
      .clk1        (clk1),
      .rst         (rst),
      .en          (en),
      .QVGA        (mif.QVGA),
      .addressVGA  (mif.addressVGA),
      .pix         (pix),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .frame_start (frame_start)
   );

   typedef struct { int col; int line; } pos_t;
   typedef struct { int kind; int ones; int f_col; int f_line; int l_col; int l_line; } vec_t;

   pos_t exp_q[$];
   vec_t vecs [5];
   int   checks = 0, failures = 0;
   int   ones, f_col, f_line, l_col, l_line, sb_err, hs_bad, vs_low;
   int   de_cnt, de_err, fs_cnt, ab_err, aseq_err, next_addr, fs_wait;
   logic cpu_wr;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int idle_vec();
      return int'({hsync, vsync, de, pix, frame_start, mif.addressVGA});
   endfunction

   task automatic fill(input int kind);
      for (int a = 0; a < 8192; a++)
         mem[a] = (kind == 4) ? ((a % 2 == 0) ? 16'hAAAA : 16'h5555) : 16'h0000;
      case (kind)
         1: mem[0]   = 16'h0001;
         2: mem[31]  = 16'hFFFF;
         3: mem[191] = 16'h8000;
         default: ;
      endcase
   endtask

   // Expected black pixels for output lines [Y0, nl), Hack bit order.
   task automatic push_exp(input int nl);
      logic [15:0] w;
      exp_q.delete();
      for (int l = Y0; l < nl; l++)
         for (int x = 0; x < 512; x++) begin
            w = mem[(l - Y0) * 32 + x / 16];
            if (w[x % 16]) exp_q.push_back('{X0 + x, l});
         end
   endtask

   task automatic wait_fs(output int n);
      n = 0;
      while (frame_start !== 1'b1 && n < 2000) begin
         @(negedge clk1);
         n++;
      end
   endtask

   task automatic mon(input int nl);
      int   col, line, lows;
      logic [12:0] prev;
      pos_t e;
      ones = 0; f_col = -1; f_line = -1; l_col = -1; l_line = -1;
      sb_err = 0; hs_bad = 0; vs_low = 0; de_cnt = 0; de_err = 0;
      fs_cnt = 0; ab_err = 0; aseq_err = 0; next_addr = 1;
      prev = '0; lows = 0;
      wait_fs(fs_wait);
      if (frame_start !== 1'b1) begin
         chk("fs_timeout", 0, 1);
         return;
      end
      for (int i = 0; i < nl * 800; i++) begin
         col  = i % 800;
         line = i / 800;
         if (cpu_wr && line == Y0 && col == 66) mem[0] = 16'hFFFF;
         if (hsync !== 1'b1) begin
            lows++;
            if (col < 656 || col > 751) hs_bad++;
         end
         if (col == 799) begin
            if (lows != 96) hs_bad++;
            lows = 0;
         end
         if (vsync !== 1'b1) vs_low++;
         if (de === 1'b1) de_cnt++;
         if (de !== ((col < 640) && (line < 480))) de_err++;
         if (frame_start === 1'b1) fs_cnt++;
         if (de !== 1'b1 && mif.addressVGA !== 13'd0) ab_err++;
         if (mif.addressVGA !== prev && mif.addressVGA !== 13'd0) begin
            if (int'(mif.addressVGA) != next_addr) aseq_err++;
            next_addr++;
         end
         prev = mif.addressVGA;
         if (pix === 1'b1) begin
            ones++;
            if (f_col < 0) begin f_col = col; f_line = line; end
            l_col = col; l_line = line;
            if (exp_q.size() == 0) sb_err++;
            else begin
               e = exp_q.pop_front();
               if (e.col != col || e.line != line) sb_err++;
            end
         end else if (pix !== 1'b0) sb_err++;
         @(negedge clk1);
      end
   endtask

   task automatic mon_checks(input string tag, input int nl, input int exp_ones, input int exp_next);
      chk({tag, "_fs_wait"}, fs_wait, 1);
      chk({tag, "_ones"}, ones, exp_ones);
      chk({tag, "_scoreboard"}, sb_err, 0);
      chk({tag, "_left"}, exp_q.size(), 0);
      chk({tag, "_hsync"}, hs_bad, 0);
      chk({tag, "_vsync_low"}, vs_low, 0);
      chk({tag, "_de_cnt"}, de_cnt, nl * 640);
      chk({tag, "_de_pos"}, de_err, 0);
      chk({tag, "_fs_cnt"}, fs_cnt, 1);
      chk({tag, "_addr_blank"}, ab_err, 0);
      chk({tag, "_addr_seq"}, aseq_err, 0);
      chk({tag, "_addr_next"}, next_addr, exp_next);
   endtask

   initial begin
      int n, idle_err;
      vecs[0] = '{0, 0,    -1,  -1, -1,  -1};   // all zero + CPU write mid-word
      vecs[1] = '{1, 1,    64,  2,  64,  2};
      vecs[2] = '{2, 16,   560, 2,  575, 2};
      vecs[3] = '{3, 1,    575, 7,  575, 7};
      vecs[4] = '{4, 2560, 65,  2,  574, 11};

      rst = 1'b1; en = 1'b0; cpu_wr = 1'b0;
      fill(0);
      repeat (3) @(negedge clk1);
      chk("reset_idle", idle_vec(), IDLE);
      rst = 1'b0;
      repeat (5) @(negedge clk1);
      chk("en_low_idle", idle_vec(), IDLE);

      for (int k = 0; k < 5; k++) begin
         rst = 1'b1; en = 1'b1;
         fill(vecs[k].kind);
         push_exp(NL);
         cpu_wr = (vecs[k].kind == 0);
         repeat (2) @(negedge clk1);
         rst = 1'b0;
         mon(NL);
         cpu_wr = 1'b0;
         mon_checks($sformatf("p%0d", k), NL, vecs[k].ones, 320);
         chk($sformatf("p%0d_first_col", k), f_col, vecs[k].f_col);
         chk($sformatf("p%0d_first_line", k), f_line, vecs[k].f_line);
         chk($sformatf("p%0d_last_col", k), l_col, vecs[k].l_col);
         chk($sformatf("p%0d_last_line", k), l_line, vecs[k].l_line);
      end

      // Reset pulse with the counters at hc=300, vc=3.
      rst = 1'b1; en = 1'b1;
      fill(4);
      repeat (2) @(negedge clk1);
      rst = 1'b0;
      wait_fs(n);
      chk("rst_first_fs", n, 1);
      repeat (2699) @(negedge clk1);
      rst = 1'b1;
      @(negedge clk1);
      chk("rst_mid_idle", idle_vec(), IDLE);
      rst = 1'b0;
      push_exp(4);
      mon(4);
      mon_checks("rst", 4, 512, 64);

      // Drop en mid-line for 10 clocks.
      repeat (150) @(negedge clk1);
      en = 1'b0;
      idle_err = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk1);
         if (idle_vec() != IDLE) idle_err++;
      end
      chk("en_drop_idle", idle_err, 0);
      en = 1'b1;
      push_exp(4);
      mon(4);
      mon_checks("en", 4, 512, 64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
